mul8_seq_ctrl: RTL and testbench
================================

Name: mul8_seq_ctrl

Overview:
Sequential 8x8 unsigned shift-and-add multiplier controller. It time-shares one instance of the existing 8-bit ripple-carry adder (8+8 -> 9-bit sum, no carry-in) across 8 iterations, one per clock. Operands arrive and the 16-bit product leaves over valid/ready handshakes. It is the area-optimised alternative to the combinational multiplier architectures.

Parameters:
N_BITS, 8, operand width; fixed at 8 because the shared adder is 8-bit. Any other value is a configuration error.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
a  in  8  multiplicand, unsigned
b  in  8  multiplier, unsigned
flush  in  1  synchronous abort, returns to IDLE
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  16  a*b, unsigned
busy  out  1  high in RUN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, all datapath registers=0.
  - in_ready=0 while rst_n=0, then 1 in IDLE from the first cycle after release.
  - out_valid=0, product=16'h0000, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0; go to RUN.
- RUN (busy=1, in_ready=0), one step per clock edge:
  - The adder computes {c, s[7:0]} = acc_hi + (acc_lo[0] ? mcand : 8'h00).
  - Shift: {acc_hi, acc_lo} <= {c, s[7:0], acc_lo[7:1]}, a 17-bit value shifted right by 1 with carry entering acc_hi[7].
  - cnt increments. After the step with cnt==7, go to DONE.
  - Exactly 8 RUN edges per operation. Latency is fixed: out_valid rises 8 cycles after the accept edge, independent of operand values. No early termination on zero.
- DONE:
  - out_valid=1, product={acc_hi, acc_lo}.
  - product is held stable while out_valid & !out_ready (backpressure of any length).
  - On out_ready: out_valid drops next cycle.
  - in_ready = out_ready during DONE. If in_valid & out_ready, the new operands load in the same edge and the state goes directly to RUN (back-to-back; throughput 1 product per 9 cycles). Otherwise go to IDLE.
- Arithmetic:
  - The carry out of the adder is never lost; the 9-bit sum feeds the shift.
  - The 16-bit product equals a*b exactly for all 65536 pairs; max is 255*255=65025.
- flush (synchronous, highest priority after reset):
  - From any state, the next edge gives state=IDLE, out_valid=0, busy=0.
  - Any in-flight or held product is discarded.
  - in_valid is ignored on the flush edge.
- Reset mid-operation: asynchronous clear as above. No partial product is ever presented.
- Stability: a and b are sampled only on the accept edge; changes during RUN have no effect.
- Protocol: out_valid never drops without out_ready or flush. in_ready is never high in RUN.

Test Plan:
1. Reset release, a=200, b=190, in_valid pulse -> busy for 8 cycles; out_valid 8 cycles after accept; product=38000 (16'h9470).
2. a=255, b=255 (max carry chain) -> product=65025 (16'hFE01); a=0, b=173 -> product=0 with latency still 8.
3. Backpressure: out_ready=0 for 5 cycles after out_valid (a=144, b=89) -> product held at 12816 and out_valid held; accepted on the cycle out_ready=1.
4. Back-to-back: in_valid held with pairs (20,50), (249,153), (80,255); out_ready=1 -> products 1000, 38097, 20400; one product per 9 cycles; no lost or duplicated transaction.
5. Reset asserted at RUN step 4 (a=189, b=190) -> outputs 0 immediately; after release, in_ready=1 and a new op (2,223) gives 446.
6. flush at RUN step 3, and flush while out_valid is held -> IDLE next edge, out_valid=0, no product emitted; the next op (a=17, b=15) gives 255.

Source files
------------

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - sequential 8x8 shift-and-add multiplier sharing one 8-bit ripple-carry adder

module mul8_rca8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [8:0] sum
);
  logic [8:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    sum[8] = carry[8];
  end
endmodule

module mul8_seq_ctrl #(
  parameter int N_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  if (N_BITS != 8) begin : g_cfg_error
    $error("mul8_seq_ctrl: N_BITS must be 8 to match the shared adder");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  acc_lo_q, acc_lo_d;
  logic [7:0]  addend;
  logic [8:0]  add_sum;
  logic        accept;

  // The multiplier bit under examination is always acc_lo[0]; its carry joins the right shift.
  assign addend = acc_lo_q[0] ? mcand_q : 8'h00;

  mul8_rca8 u_adder (
    .x   (acc_hi_q),
    .y   (addend),
    .sum (add_sum)
  );

  assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign product   = out_valid ? {acc_hi_q, acc_lo_q} : 16'h0000;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mcand_d  = a;
          acc_hi_d = 8'h00;
          acc_lo_d = b;
          cnt_d    = 3'd0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            mcand_d  = a;
            acc_hi_d = 8'h00;
            acc_lo_d = b;
            cnt_d    = 3'd0;
            state_d  = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including an operand pair offered on the same edge.
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      mcand_d  = 8'h00;
      acc_hi_d = 8'h00;
      acc_lo_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      mcand_q  <= 8'h00;
      acc_hi_q <= 8'h00;
      acc_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - directed and randomized checks of mul8_seq_ctrl against an arithmetic model

module tb_mul8_seq_ctrl;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_total;
  int n_pass;
  int n_fail;

  mul8_seq_ctrl #(.N_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p;
  endfunction

  // One complete operation from IDLE: accept, 8 busy cycles, optional backpressure, handshake.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input int bp);
    int lat;
    logic [31:0] exp;
    exp       = model_mul(ta, tb);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    check("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    lat      = 0;
    while (!out_valid && lat < 20) begin
      check("busy_in_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      tick();
      lat++;
    end
    check("latency", lat, 8);
    check("product", product, exp);
    check("busy_done", busy, 0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("held_valid", out_valid, 1);
      check("held_product", product, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("back_to_idle", in_ready, 1);
  endtask

  initial begin
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    int lat;
    int gap;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;

    n_total   = 0;
    n_pass    = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    do_op(8'd200, 8'd190, 0);
    do_op(8'd255, 8'd255, 0);
    do_op(8'd0, 8'd173, 0);
    do_op(8'd144, 8'd89, 5);

    // Back-to-back with in_valid held high and the consumer always ready.
    pa[0] = 8'd20;  pb[0] = 8'd50;
    pa[1] = 8'd249; pb[1] = 8'd153;
    pa[2] = 8'd80;  pb[2] = 8'd255;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = pa[0];
    b = pb[0];
    tick();
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        a = pa[k + 1];
        b = pb[k + 1];
      end else begin
        in_valid = 1'b0;
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("b2b_latency", lat, 8);
      check("b2b_product", product, model_mul(pa[k], pb[k]));
      check("b2b_in_ready", in_ready, 1);
      if (out_valid) seen++;
      tick();
      gap = lat + 1;
      check("b2b_period", gap, 9);
    end
    out_ready = 1'b0;
    check("b2b_count", seen, 3);
    check("b2b_idle_after", out_valid, 0);
    check("b2b_busy_after", busy, 0);

    // Asynchronous reset in the middle of RUN.
    in_valid = 1'b1;
    a = 8'd189;
    b = 8'd190;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    check("midrst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_release_ready", in_ready, 1);
    do_op(8'd2, 8'd223, 0);

    // flush during RUN, with an operand pair offered on the flush edge.
    in_valid = 1'b1;
    a = 8'd99;
    b = 8'd77;
    tick();
    a = 8'd5;
    b = 8'd6;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_run_busy", busy, 0);
    check("flush_run_valid", out_valid, 0);
    check("flush_run_idle", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    check("flush_no_product", seen, 0);

    // flush while a product is held under backpressure.
    in_valid = 1'b1;
    a = 8'd33;
    b = 8'd44;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("flush_hold_valid", out_valid, 1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hold_drop", out_valid, 0);
    check("flush_hold_product", product, 0);
    check("flush_hold_busy", busy, 0);
    do_op(8'd17, 8'd15, 0);

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
